// File: rtl/mult_bus_master.sv
// Bus-side initiator for the shared-databus multiplier: sends operands A then B
// over the tri-state bus, collects the product bytes and returns them on a response port.
module mult_bus_master #(
  parameter int WIDTH   = 8,
  parameter int OP_GAP  = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_product,
  output logic                 rsp_err,
  output logic                 start,
  inout  wire  [WIDTH-1:0]     databus,
  input  logic                 msb_out,
  input  logic                 lsb_out,
  input  logic                 done
);

  localparam int GW = (OP_GAP > 1) ? $clog2(OP_GAP) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_GAP   = 3'd2,
    S_OP1   = 3'd3,
    S_OP2   = 3'd4,
    S_WAIT  = 3'd5,
    S_RESP  = 3'd6
  } state_t;

  state_t               state_r;
  logic                 start_r;
  logic                 bus_en_r;
  logic [WIDTH-1:0]     bus_data_r;
  logic [WIDTH-1:0]     op_a_r;
  logic [WIDTH-1:0]     op_b_r;
  logic [2*WIDTH-1:0]   prod_r;
  logic                 got_msb_r;
  logic                 got_lsb_r;
  logic                 proto_err_r;
  logic [TW-1:0]        timer_r;
  logic [GW-1:0]        gap_cnt_r;
  logic                 rsp_valid_r;
  logic [2*WIDTH-1:0]   rsp_product_r;
  logic                 rsp_err_r;

  logic [2*WIDTH-1:0]   prod_s;
  logic                 got_msb_s;
  logic                 got_lsb_s;
  logic                 proto_err_s;
  logic                 err_s;

  assign req_ready   = (state_r == S_IDLE);
  assign start       = start_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_product = rsp_product_r;
  assign rsp_err     = rsp_err_r;
  assign databus     = bus_en_r ? bus_data_r : {WIDTH{1'bz}};

  // Strobe capture for the current cycle, so a strobe coincident with done is included.
  always_comb begin
    prod_s      = prod_r;
    got_msb_s   = got_msb_r;
    got_lsb_s   = got_lsb_r;
    proto_err_s = proto_err_r;
    if (msb_out && lsb_out) begin
      proto_err_s = 1'b1;
    end else if (msb_out) begin
      prod_s[2*WIDTH-1:WIDTH] = databus;
      got_msb_s               = 1'b1;
    end else if (lsb_out) begin
      prod_s[WIDTH-1:0] = databus;
      got_lsb_s         = 1'b1;
    end else begin
      prod_s = prod_r;
    end
    err_s = proto_err_s | ~got_msb_s | ~got_lsb_s;
  end

  // Transaction FSM with registered start, bus drive and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      start_r       <= 1'b0;
      bus_en_r      <= 1'b0;
      bus_data_r    <= {WIDTH{1'b0}};
      op_a_r        <= {WIDTH{1'b0}};
      op_b_r        <= {WIDTH{1'b0}};
      prod_r        <= {(2*WIDTH){1'b0}};
      got_msb_r     <= 1'b0;
      got_lsb_r     <= 1'b0;
      proto_err_r   <= 1'b0;
      timer_r       <= {TW{1'b0}};
      gap_cnt_r     <= {GW{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_product_r <= {(2*WIDTH){1'b0}};
      rsp_err_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            state_r     <= S_START;
            start_r     <= 1'b1;
            op_a_r      <= req_a;
            op_b_r      <= req_b;
            prod_r      <= {(2*WIDTH){1'b0}};
            got_msb_r   <= 1'b0;
            got_lsb_r   <= 1'b0;
            proto_err_r <= 1'b0;
            timer_r     <= {TW{1'b0}};
          end
        end
        S_START: begin
          start_r <= 1'b0;
          if (OP_GAP == 0) begin
            state_r    <= S_OP1;
            bus_en_r   <= 1'b1;
            bus_data_r <= op_a_r;
          end else begin
            state_r   <= S_GAP;
            gap_cnt_r <= {GW{1'b0}};
          end
        end
        S_GAP: begin
          if (gap_cnt_r == GW'(OP_GAP - 1)) begin
            state_r    <= S_OP1;
            bus_en_r   <= 1'b1;
            bus_data_r <= op_a_r;
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
          end
        end
        S_OP1: begin
          state_r    <= S_OP2;
          bus_data_r <= op_b_r;
        end
        S_OP2: begin
          state_r    <= S_WAIT;
          bus_en_r   <= 1'b0;
          bus_data_r <= {WIDTH{1'b0}};
          timer_r    <= {TW{1'b0}};
        end
        S_WAIT: begin
          prod_r      <= prod_s;
          got_msb_r   <= got_msb_s;
          got_lsb_r   <= got_lsb_s;
          proto_err_r <= proto_err_s;
          if (done) begin
            state_r       <= S_RESP;
            rsp_valid_r   <= 1'b1;
            rsp_product_r <= prod_s;
            rsp_err_r     <= err_s;
          end else if (timer_r == TW'(TIMEOUT - 1)) begin
            // Timeout: the partial product is discarded.
            state_r       <= S_RESP;
            rsp_valid_r   <= 1'b1;
            rsp_product_r <= {(2*WIDTH){1'b0}};
            rsp_err_r     <= 1'b1;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_r     <= S_IDLE;
            rsp_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          start_r     <= 1'b0;
          bus_en_r    <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
